// File: rtl/uart_rx_byte.sv
//------------------------------------------------------------------------------
// Module      : uart_rx_byte
// Description : 8N1 asynchronous serial receiver. The raw RX pin is brought
//               into the clk domain through a two-flop synchronizer. Each
//               bit is sampled at its midpoint. Good bytes are presented on
//               rx_data with a one-cycle rbyte_ready strobe. A low stop bit
//               gives a one-cycle frame_err strobe, and the byte is dropped.
// Ports       :
//   clk          in   1  system clock, all logic on posedge
//   rst          in   1  asynchronous reset, active low (0 = reset)
//   rx           in   1  raw serial line, idle high, asynchronous to clk
//   rx_data      out  8  last correctly framed byte, held until next good byte
//   rbyte_ready  out  1  one-cycle pulse, rx_data updates on the same edge
//   frame_err    out  1  one-cycle pulse, stop bit sampled low
//   busy         out  1  high while the receiver is not idle
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rbyte_ready,
  output logic       frame_err,
  output logic       busy
);

  // Terminal counts. START ends at the middle of the start bit.
  // Each later bit ends one full bit period after the previous sample.
  localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  // Registered state
  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shreg;
  logic [7:0]  r_rx_data;
  logic        r_rbyte_ready;
  logic        r_frame_err;

  // Next-state values
  logic        w_rx_s;
  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  w_shreg_nxt;
  logic [7:0]  w_rx_data_nxt;
  logic        w_rbyte_ready_nxt;
  logic        w_frame_err_nxt;

  //--------------------------------------------------------------------------
  // Input synchronizer. It resets to the idle (high) line level, so a
  // reset does not look like a start edge.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 16'd0;
      r_idx         <= 3'd0;
      r_shreg       <= 8'h00;
      r_rx_data     <= 8'h00;
      r_rbyte_ready <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_shreg       <= w_shreg_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_rbyte_ready <= w_rbyte_ready_nxt;
      r_frame_err   <= w_frame_err_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic. The counter clears every time the FSM enters a state,
  // so each terminal count is measured from that entry.
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt + 16'd1;
    w_idx_nxt         = r_idx;
    w_shreg_nxt       = r_shreg;
    w_rx_data_nxt     = r_rx_data;
    w_rbyte_ready_nxt = 1'b0;
    w_frame_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt = 16'd0;
          if (!w_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = 3'd0;
          end else begin
            // The line went high again before mid-start: treat it as a
            // glitch and drop it silently.
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt   = 16'd0;
          w_shreg_nxt = {w_rx_s, r_shreg[7:1]};   // LSB arrives first
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end

      S_STOP: begin
        // The FSM decides at mid-stop, so IDLE is ready again before the
        // stop bit ends. A start bit can then follow right after it.
        if (r_cnt == c_BIT_LAST) begin
          w_cnt_nxt = 16'd0;
          if (w_rx_s) begin
            w_rx_data_nxt     = r_shreg;
            w_rbyte_ready_nxt = 1'b1;
            w_state_nxt       = S_IDLE;
          end else begin
            w_frame_err_nxt   = 1'b1;
            w_state_nxt       = S_WAIT_HIGH;
          end
        end
      end

      S_WAIT_HIGH: begin
        // A held-low line (break) must not be taken as a new start bit.
        w_cnt_nxt = 16'd0;
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_cnt_nxt   = 16'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign rx_data     = r_rx_data;
  assign rbyte_ready = r_rbyte_ready;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_rx_byte
// Description : Self-checking bench for uart_rx_byte (CLKS_PER_BIT = 16).
//               Sent frames push the expected event onto a scoreboard.
//               A negedge monitor pops and compares each strobe as it occurs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_byte;

  localparam int  CPB    = 16;
  localparam int  HALF   = CPB / 2;
  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = CPB * CLK_NS;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rbyte_ready;
  logic       frame_err;
  logic       busy;

  ev_t        q[$];
  logic [7:0] last_good;
  int         n_checks;
  int         n_errors;
  int         n_ready;
  int         n_ferr;
  int         exp_ready;
  int         exp_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rbyte_ready (rbyte_ready),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2.0) clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one 8N1 frame. When track is set, the expected outcome is pushed.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit,
                           input real bit_ns, input bit track);
    if (track) begin
      if (stop_bit) begin
        q.push_back('{is_err: 1'b0, data: d});
        exp_ready++;
      end else begin
        q.push_back('{is_err: 1'b1, data: 8'h00});
        exp_ferr++;
      end
    end
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", 32'(n < 4000), 32'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      last_good = 8'h00;
    end else begin
      if (rbyte_ready && frame_err) check_eq("both_strobes", 32'd1, 32'd0);
      if (rbyte_ready || frame_err) begin
        if (q.size() == 0) begin
          check_eq("spurious_strobe", 32'd1, 32'd0);
        end else begin
          ev_t ev;
          ev = q.pop_front();
          check_eq("strobe_kind", 32'(frame_err), 32'(ev.is_err));
          if (rbyte_ready) begin
            n_ready++;
            check_eq("rx_data", 32'(rx_data), 32'(ev.data));
            last_good = ev.data;
          end else begin
            n_ferr++;
            check_eq("rx_data_hold", 32'(rx_data), 32'(last_good));
          end
        end
      end else begin
        check_eq("rx_data_stable", 32'(rx_data), 32'(last_good));
      end
    end
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    int ready_before;
    int ferr_before;
    n_checks  = 0;
    n_errors  = 0;
    n_ready   = 0;
    n_ferr    = 0;
    exp_ready = 0;
    exp_ferr  = 0;
    last_good = 8'h00;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_rx_data", 32'(rx_data), 32'h00);
    check_eq("rst_ready", 32'(rbyte_ready), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single byte. Also measure latency from the start edge to the strobe.
    fork
      send_byte(8'h7E, 1'b1, BIT_NS, 1'b1);
      begin
        int n = 0;
        while (rbyte_ready !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        check_eq("t1_latency", 32'(n), 32'(9 * CPB + HALF + 3));
      end
    join
    wait_idle();
    check_eq("t1_ready_cnt", 32'(n_ready), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // 2: back-to-back header and payload with one stop bit each
    @(negedge clk);
    send_byte(8'h7E, 1'b1, BIT_NS, 1'b1);
    send_byte(8'h30, 1'b1, BIT_NS, 1'b1);
    send_byte(8'h5F, 1'b1, BIT_NS, 1'b1);
    send_byte(8'h12, 1'b1, BIT_NS, 1'b1);
    send_byte(8'h34, 1'b1, BIT_NS, 1'b1);
    wait_idle();
    check_eq("t2_ready_cnt", 32'(n_ready), 32'd6);

    // 3: short low glitch is rejected at mid-start
    ready_before = n_ready;
    ferr_before  = n_ferr;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t3_busy_start", 32'(busy), 32'd1);
    @(negedge clk);
    rx = 1'b1;
    repeat (HALF + 3) @(negedge clk);
    check_eq("t3_busy_end", 32'(busy), 32'd0);
    check_eq("t3_no_ready", 32'(n_ready), 32'(ready_before));
    check_eq("t3_no_ferr", 32'(n_ferr), 32'(ferr_before));

    // 4: framing error, line held low, then a good byte
    @(negedge clk);
    send_byte(8'h55, 1'b0, BIT_NS, 1'b1);
    repeat (100) @(negedge clk);
    check_eq("t4_wait_high_busy", 32'(busy), 32'd1);
    check_eq("t4_hold_data", 32'(rx_data), 32'h34);
    rx = 1'b1;
    #(2.0 * BIT_NS);
    wait_idle();
    check_eq("t4_ferr_cnt", 32'(n_ferr), 32'd1);
    @(negedge clk);
    send_byte(8'hA5, 1'b1, BIT_NS, 1'b1);
    wait_idle();
    check_eq("t4_rx_data", 32'(rx_data), 32'hA5);

    // 5: reset mid-frame (during bit 4 of 8'hC3), held until the line is idle
    ready_before = n_ready;
    @(negedge clk);
    fork
      send_byte(8'hC3, 1'b1, BIT_NS, 1'b0);
      begin
        #(5.5 * BIT_NS);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t5_rst_rx_data", 32'(rx_data), 32'h00);
        check_eq("t5_rst_ready", 32'(rbyte_ready), 32'd0);
        check_eq("t5_rst_ferr", 32'(frame_err), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
      end
    join
    @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_eq("t5_no_strobe", 32'(n_ready), 32'(ready_before));
    check_eq("t5_post_busy", 32'(busy), 32'd0);
    send_byte(8'h3C, 1'b1, BIT_NS, 1'b1);
    wait_idle();
    check_eq("t5_rx_data", 32'(rx_data), 32'h3C);

    // 6: baud skew of +3% and -3%
    ferr_before = n_ferr;
    send_byte(8'h00, 1'b1, BIT_NS * 1.03, 1'b1);
    send_byte(8'hFF, 1'b1, BIT_NS * 1.03, 1'b1);
    send_byte(8'h00, 1'b1, BIT_NS * 0.97, 1'b1);
    send_byte(8'hFF, 1'b1, BIT_NS * 0.97, 1'b1);
    wait_idle();
    check_eq("t6_no_ferr", 32'(n_ferr), 32'(ferr_before));

    // Totals
    repeat (4) @(negedge clk);
    check_eq("total_ready", 32'(n_ready), 32'(exp_ready));
    check_eq("total_ferr", 32'(n_ferr), 32'(exp_ferr));
    check_eq("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
